uart_tx_scheduler: RTL and testbench

Shares a single UART transmit line between `NUM_REQ` byte producers. Arbitrates round-robin among requesters, accepts one byte with a valid/ready handshake, and serializes it as an 8N1 frame at a programmable bit period. Sits between the system's byte sources (debug, status, log streams) and the board-level TX pin, and replaces free-running serialization with demand-driven, baud-timed framing.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_gen.sv | 34 +++
 rtl/uart_tx_scheduler.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the round-robin UART transmit scheduler.
// The optional parity stage is enabled with the UART_TX_PARITY_EN macro.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_done on the
// terminal count. clear forces the count back to zero.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_done = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || bit_done) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter plus 8N1 serializer sharing one UART TX line.
// Defining UART_TX_PARITY_EN inserts an even-parity bit before STOP.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [2:0]                 dbg_state
);

  localparam int GW = $clog2(NUM_REQ);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t state_q, state_d;
  logic                      tx_q, tx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [GW-1:0]             grant_q, grant_d;
  logic [GW-1:0]             last_q, last_d;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  logic          bit_done;
  logic          win_found;
  logic [GW-1:0] win_idx;
  logic [GW:0]   cand;
  logic [7:0]    win_data;
  logic          accept;

  // Handshake: a byte moves on a rising edge where req_valid[i] && req_ready[i];
  // req_ready is only ever raised in IDLE, one-hot, for the round-robin winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + (GW+1)'(k);
      if (cand >= (GW+1)'(NUM_REQ)) begin
        cand = cand - (GW+1)'(NUM_REQ);
      end
      if (!win_found && req_valid[cand[GW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[GW-1:0];
      end
    end
  end

  assign accept    = (state_q == IDLE) && win_found;
  assign req_ready = accept ? (NUM_REQ'(1) << win_idx) : '0;
  assign win_data  = req_data[{win_idx, 3'b000} +: 8];

  // Holding the timer clear while idle makes the START bit begin at count 0.
  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (state_q == IDLE),
    .bit_done (bit_done)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    grant_d   = grant_q;
    last_d    = last_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          shift_d   = win_data;
          bit_idx_d = '0;
          grant_d   = win_idx;
          last_d    = win_idx;
`ifdef UART_TX_PARITY_EN
          parity_d  = even_parity(win_data);
`endif
        end
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The line level is decided from the next state so tx leaves a flop.
  always_comb begin
    tx_d = UART_IDLE_LEVEL;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = parity_q;
`endif
      default: tx_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tx_q      <= UART_IDLE_LEVEL;
      shift_q   <= '0;
      bit_idx_q <= '0;
      grant_q   <= '0;
      last_q    <= GW'(NUM_REQ - 1);
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized scoreboard bench: a round-robin model predicts (requester, byte)
// frames; a line monitor decodes tx and checks each frame against the queue.
module tb_uart_tx_scheduler;

  localparam int NR  = 4;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR*8-1:0] req_data = '0;
  logic [NR-1:0] req_ready;
  logic          tx;
  logic          busy;
  logic [1:0]    grant_id;
  logic [2:0]    dbg_state;

  uart_tx_scheduler #(
    .NUM_REQ      (NR),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];   // {requester id, byte}
  int  m_last = NR - 1;   // model of the arbiter's last grant
  bit  mon_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic int rr_next(input int last, input logic [NR-1:0] pend);
    for (int k = 1; k <= NR; k++) begin
      int c = (last + k) % NR;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_batch(input logic [NR-1:0] mask, input logic [NR*8-1:0] data,
                           input bit hold, input int n_acc);
    logic [NR-1:0] pend;
    logic [NR-1:0] acc;
    int order[$];
    int w;
    int got;
    int cyc;
    pend = mask;
    for (int i = 0; i < n_acc; i++) begin
      w = rr_next(m_last, pend);
      m_last = w;
      order.push_back(w);
      exp_q.push_back({w[1:0], data[8*w +: 8]});
      if (!hold) pend[w] = 1'b0;
    end
    @(posedge clk); #1;
    req_data  = data;
    req_valid = mask;
    got = 0;
    cyc = 0;
    while (got < n_acc && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      acc = req_valid & req_ready;
      if (acc != '0) begin
        check("accept_onehot", 32'(req_ready), 32'(1) << order[got]);
        got++;
        @(posedge clk); #1;
        if (!hold) req_valid = req_valid & ~acc;
        if (got == n_acc) req_valid = '0;
      end
    end
    if (got < n_acc) begin
      timeout("accept_wait");
      req_valid = '0;
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || busy) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 3000) timeout("drain_wait");
    repeat (2) @(negedge clk);
    check("grant_hold", 32'(grant_id), 32'(m_last));
  endtask

  // ---------------- monitor ----------------
  logic [7:0] mon_b;
  logic [9:0] mon_e;
  logic [1:0] mon_id;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && reset_n && tx === 1'b0) begin
        mon_id = grant_id;
        check("busy_start", 32'(busy), 32'd1);
        repeat (CPB/2) @(negedge clk);
        check("start_bit", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mon_b[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        check("parity_bit", 32'(tx), 32'(^mon_b));
`endif
        repeat (CPB) @(negedge clk);
        check("stop_bit", 32'(tx), 32'd1);
        if (exp_q.size() == 0) begin
          timeout("unexpected_frame");
        end else begin
          mon_e = exp_q.pop_front();
          check("frame_id", 32'(mon_id), 32'(mon_e[9:8]));
          check("frame_byte", 32'(mon_b), 32'(mon_e[7:0]));
        end
        repeat (CPB/2 - 1) @(negedge clk);
        check("busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_end", 32'(busy), 32'd0);
        check("idle_gap", 32'(tx), 32'd1);
      end
    end
  end

  // ---------------- stimulus ----------------
  int cyc_w;

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_after_rst", 32'({tx, busy, req_ready, grant_id}), 32'({1'b1, 1'b0, 4'b0000, 2'b00}));
    end

    // single byte from requester 0
    run_batch(4'b0001, 32'h0000_00A5, 1'b0, 1);
    drain();
    // four simultaneous requesters
    run_batch(4'b1111, 32'h4433_2211, 1'b0, 4);
    drain();
    // requesters 0 and 2 held valid across four frames
    run_batch(4'b0101, $urandom, 1'b1, 4);
    drain();

    // random batches, sometimes back-to-back with frames in flight
    for (int b = 0; b < 12; b++) begin
      logic [NR-1:0] m;
      m = NR'($urandom_range(1, 15));
      run_batch(m, $urandom, 1'b0, $countones(m));
      if ($urandom_range(0, 1) == 0) drain();
    end
    drain();

    // reset in the middle of DATA bit 3, then fresh requests
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    @(posedge clk); #1;
    req_data  = $urandom;
    req_valid = 4'b0001;
    cyc_w = 0;
    while (req_ready[0] !== 1'b1 && cyc_w < 100) begin
      @(negedge clk);
      cyc_w++;
    end
    if (cyc_w >= 100) timeout("mid_rst_accept");
    @(posedge clk); #1;
    req_valid = '0;
    repeat (CPB + 3*CPB + 1) @(posedge clk);
    #2;
    check("busy_before_rst", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd0);
    check("midrst_grant", 32'(grant_id), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_last = NR - 1;
    repeat (2) @(negedge clk);
    check("post_rst_tx", 32'(tx), 32'd1);
    mon_en = 1'b1;
    run_batch(4'b0011, $urandom, 1'b0, 2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
